// File: rtl/led_pulse_stretch_pkg.sv
// Shared types and helpers for the LED pulse stretcher.
package led_pulse_stretch_pkg;

    // Blink sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // Timer width: clog2 of the longer phase, never narrower than one bit
    function automatic int unsigned timer_width(int unsigned on_cycles, int unsigned off_cycles);
        int unsigned longest;
        longest = (on_cycles > off_cycles) ? on_cycles : off_cycles;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/led_pulse_stretch_timer.sv
// Loadable down-counter that stops at zero and flags it.
module led_pulse_stretch_timer #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    // Load takes priority; otherwise count down and hold at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/led_pulse_stretch.sv
// LED pulse stretcher: every event strobe becomes one ON/GAP blink, extra events are queued.
// Optional PWM dimming during ON is enabled by defining LED_PULSE_STRETCH_PWM_EN.
module led_pulse_stretch
    import led_pulse_stretch_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = 1000000,
    parameter int unsigned OFF_CYCLES = 500000,
    parameter int unsigned PEND_W     = 4,
    parameter int unsigned PWM_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_evt,
`ifdef LED_PULSE_STRETCH_PWM_EN
    input  logic [PWM_W-1:0]  i_duty,
`endif
    output logic              o_led,
    output logic              o_busy,
    output logic [PEND_W-1:0] o_pending,
    output logic              o_overflow
);

    localparam int unsigned       TIMER_W  = timer_width(ON_CYCLES, OFF_CYCLES);
    localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0]  PEND_MAX = '1;

    state_e              state_q, state_d;
    logic [PEND_W-1:0]   pending_q, pending_d;
    logic                led_q, led_d;
    logic                ovf_q;
    logic                timer_load;
    logic [TIMER_W-1:0]  timer_val;
    logic                timer_zero;
    logic                pend_nz;
    logic                inc, dec, drop;

    assign pend_nz = (pending_q != '0);

    led_pulse_stretch_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    // Next state, timer reload and queue increment/decrement requests
    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        timer_val  = ON_LOAD;
        inc        = 1'b0;
        dec        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_evt || pend_nz) begin
                    state_d    = ST_ON;
                    timer_load = 1'b1;
                    timer_val  = ON_LOAD;
                    // A queued event starts first; a fresh one then joins the queue
                    dec        = pend_nz;
                    inc        = i_evt && pend_nz;
                end
            end
            ST_ON: begin
                inc = i_evt;
                if (timer_zero) begin
                    state_d    = ST_GAP;
                    timer_load = 1'b1;
                    timer_val  = OFF_LOAD;
                end
            end
            ST_GAP: begin
                inc = i_evt;
                if (timer_zero) begin
                    if (pend_nz) begin
                        state_d    = ST_ON;
                        timer_load = 1'b1;
                        timer_val  = ON_LOAD;
                        dec        = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Queue update; a simultaneous decrement always makes room
    always_comb begin
        drop      = inc && !dec && (pending_q == PEND_MAX);
        pending_d = pending_q;
        if (inc && !dec && !drop) begin
            pending_d = pending_q + 1'b1;
        end else if (dec && !inc) begin
            pending_d = pending_q - 1'b1;
        end
    end

`ifdef LED_PULSE_STRETCH_PWM_EN
    logic [PWM_W-1:0] pwm_q, pwm_d;

    assign pwm_d = pwm_q + 1'b1;

    // Free-running PWM slot counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    // Compare against the slot the LED register will present next cycle
    assign led_d = (state_d == ST_ON) && (pwm_d < i_duty);
`else
    assign led_d = (state_d == ST_ON);

    // PWM_W is only meaningful in the PWM build
    if (PWM_W == 0) begin : g_no_pwm
    end
`endif

    // Sequencer state, queue and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            led_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            led_q     <= led_d;
            ovf_q     <= drop;
        end
    end

    assign o_led      = led_q;
    assign o_overflow = ovf_q;
    assign o_pending  = pending_q;
    assign o_busy     = (state_q != ST_IDLE) || pend_nz;

endmodule
